// File: rtl/sdc_cmd_serializer.sv
// Parallel-to-serial SD command serializer, MSB first, paced by shift_en.
// Define SDC_CRC7_EN to replace the frame's last 8 bits with CRC7 and end bit.
module sdc_cmd_serializer #(
    parameter int unsigned FRAME_W    = 48,
    parameter bit          IDLE_LEVEL = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_valid,
    output logic               load_ready,
    input  logic [FRAME_W-1:0] full_cmd,
    input  logic               shift_en,
    output logic               command,
    output logic               busy,
    output logic               done
);

    localparam int unsigned CW = $clog2(FRAME_W + 1);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e             state_q, state_d;
    logic [FRAME_W-1:0] sreg_q, sreg_d;
    logic [CW-1:0]      count_q, count_d;
    logic               last_bit;
    logic               line_bit;

    // count_q is the index of the bit currently on the line
    assign last_bit = (count_q == CW'(FRAME_W - 1));

`ifdef SDC_CRC7_EN
    logic [6:0] crc_q, crc_d;
    logic       crc_phase;
    logic [2:0] crc_idx;

    assign crc_phase = (count_q >= CW'(FRAME_W - 8)) && !last_bit;
    assign crc_idx   = 3'(CW'(FRAME_W - 2) - count_q);

    always_comb begin
        line_bit = sreg_q[FRAME_W-1];
        if (last_bit) begin
            line_bit = 1'b1;
        end else if (crc_phase) begin
            line_bit = crc_q[crc_idx];
        end
    end

    // CRC accumulates the payload bits only, then holds while it is sent
    always_comb begin
        crc_d = crc_q;
        if (state_q == StIdle && load_valid) begin
            crc_d = '0;
        end else if (state_q == StShift && shift_en && !crc_phase && !last_bit) begin
            crc_d = {crc_q[5:0], 1'b0} ^ ({7{line_bit ^ crc_q[6]}} & 7'h09);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end
`else
    assign line_bit = sreg_q[FRAME_W-1];
`endif

    always_comb begin
        state_d    = state_q;
        sreg_d     = sreg_q;
        count_d    = count_q;
        load_ready = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        command    = IDLE_LEVEL;
        unique case (state_q)
            StIdle: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    sreg_d  = full_cmd;
                    count_d = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                busy    = 1'b1;
                command = line_bit;
                if (shift_en) begin
                    sreg_d  = {sreg_q[FRAME_W-2:0], IDLE_LEVEL};
                    count_d = count_q + CW'(1);
                    if (last_bit) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            sreg_q  <= {FRAME_W{IDLE_LEVEL}};
            count_q <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_sdc_cmd_serializer.sv
// Scoreboard bench for sdc_cmd_serializer: stimulus pushes expected frames,
// a monitor rebuilds frames from the line and compares on each done pulse.
module tb_sdc_cmd_serializer;

    localparam int unsigned FW = 48;

    logic          clk = 1'b0;
    logic          reset;
    logic          load_valid;
    logic          load_ready;
    logic [FW-1:0] full_cmd;
    logic          shift_en;
    logic          command;
    logic          busy;
    logic          done;

    int            n_checks = 0;
    int            n_fail   = 0;
    int            cyc      = 0;
    int            se_mode  = 0;  // 0 off, 1 always, 2 every 4th, 3 random
    logic [FW-1:0] exp_q[$];

    sdc_cmd_serializer #(.FRAME_W(FW), .IDLE_LEVEL(1'b1)) dut (
        .clk       (clk),
        .reset     (reset),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .full_cmd  (full_cmd),
        .shift_en  (shift_en),
        .command   (command),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
    endtask

    // Reference: SD frame whose tail is CRC7 remainder of payload*x^7 plus end bit
    function automatic logic [FW-1:0] model(input logic [FW-1:0] d);
`ifdef SDC_CRC7_EN
        logic [FW-2:0] m;
        m = {d[FW-1:8], 7'b0};
        for (int i = FW - 2; i >= 7; i--) begin
            if (m[i]) m = m ^ ((FW-1)'(8'h89) << (i - 7));
        end
        return {d[FW-1:8], m[6:0], 1'b1};
`else
        return d;
`endif
    endfunction

    function automatic logic [FW-1:0] rnd();
        return {16'($urandom), $urandom};
    endfunction

    // Strobe generator
    initial begin
        int pace = 0;
        shift_en = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (se_mode)
                1:       shift_en = 1'b1;
                2:       shift_en = (pace % 4 == 3);
                3:       shift_en = ($urandom_range(0, 2) == 0);
                default: shift_en = 1'b0;
            endcase
            pace++;
        end
    end

    // Monitor: captures a bit whenever a strobe is about to advance the line
    initial begin
        logic [FW-1:0] cap = '0;
        int            nbits = 0;
        logic          prev_busy = 1'b0, prev_se = 1'b0, prev_cmd = 1'b1;
        forever begin
            @(negedge clk);
            if (reset) begin
                cap   = '0;
                nbits = 0;
            end else begin
                if (prev_busy && busy && !prev_se) check("bit_hold", command, prev_cmd);
                if (busy && shift_en) begin
                    cap = {cap[FW-2:0], command};
                    nbits++;
                end
                if (done) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_done", 1, 0);
                    end else begin
                        check("frame", cap, exp_q.pop_front());
                        check("frame_bits", nbits, FW);
                    end
                    nbits = 0;
                end
            end
            prev_busy = busy;
            prev_se   = shift_en;
            prev_cmd  = command;
        end
    end

    task automatic accept(input logic [FW-1:0] d, output int t);
        int n = 0;
        @(negedge clk);
        while (!load_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!load_ready) fail("accept_wait");
        load_valid = 1'b1;
        full_cmd   = d;
        @(posedge clk);
        #1;
        t          = cyc;
        load_valid = 1'b0;
        full_cmd   = rnd();
    endtask

    task automatic wait_done(input int t, input bit timed);
        int n = 0;
        @(negedge clk);
        while (!done && n < 1000) begin
            check("busy_in_frame", busy, 1);
            @(negedge clk);
            n++;
        end
        if (!done) begin
            fail("done_wait");
        end else if (timed) begin
            check("done_cycle", cyc - t, FW);
            check("done_busy", busy, 0);
            @(negedge clk);
            check("ready_after_done", load_ready, 1);
            check("done_one_cycle", done, 0);
        end
    endtask

    initial begin
        int            t, t1;
        logic [FW-1:0] d, e, d2;
        bit            saw_done;
        reset = 1'b1; load_valid = 1'b0; full_cmd = '0;
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int            t, t1, n;
        logic [FW-1:0] d, e, d2;
        bit            saw_done;
        reset = 1'b1; load_valid = 1'b0; full_cmd = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Idle after reset; strobes must not disturb the line
        @(negedge clk);
        check("rst_command", command, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ready", load_ready, 1);
        se_mode = 1;
        repeat (20) begin
            @(negedge clk);
            check("idle_outputs", {command, busy, done, load_ready}, 4'b1001);
        end

        // CMD0 with continuous strobes, cycle-exact timing
`ifdef SDC_CRC7_EN
        d = 48'h4000000000FF;
`else
        d = 48'h400000000095;
`endif
        e = 48'h400000000095;
        exp_q.push_back(e);
        accept(d, t);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("cmd0_bit", command, e[FW-1-k]);
        end
        wait_done(t, 1'b1);

        // Paced shifting with an ignored mid-frame load
        se_mode = 2;
`ifdef SDC_CRC7_EN
        d = 48'h48000001AA00;
`else
        d = 48'h48000001AA87;
`endif
        exp_q.push_back(48'h48000001AA87);
        accept(d, t);
        repeat (30) @(negedge clk);
        load_valid = 1'b1;
        full_cmd   = rnd();
        @(negedge clk);
        load_valid = 1'b0;
        wait_done(t, 1'b0);

        // Random frames under continuous and random strobes
        for (int i = 0; i < 8; i++) begin
            se_mode = (i % 2 == 0) ? 1 : 3;
            d = rnd();
            exp_q.push_back(model(d));
            accept(d, t);
            wait_done(t, se_mode == 1);
        end

        // Reset mid-frame: frame discarded, no done
        se_mode = 1;
        accept(rnd(), t);
        repeat (20) @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("abort_command", command, 1);
        check("abort_ready", load_ready, 1);
        check("abort_busy", busy, 0);
        saw_done = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        check("abort_no_done", saw_done, 0);
        d = rnd();
        exp_q.push_back(model(d));
        accept(d, t);
        wait_done(t, 1'b1);

        // Back-to-back: load_valid held, second frame taken as soon as ready
        d  = rnd();
        d2 = rnd();
        exp_q.push_back(model(d));
        exp_q.push_back(model(d2));
        @(negedge clk);
        load_valid = 1'b1;
        full_cmd   = d;
        @(posedge clk);
        #1;
        t1       = cyc;
        full_cmd = d2;
        n        = 0;
        @(negedge clk);
        while (!load_ready && n < 200) begin
            if (cyc - t1 >= FW) check("gap_idle_level", command, 1);
            @(negedge clk);
            n++;
        end
        if (!load_ready) fail("b2b_ready_wait");
        check("b2b_accept_cycle", cyc - t1, FW + 1);
        check("b2b_accept_line", command, 1);
        @(posedge clk);
        #1;
        t          = cyc;
        load_valid = 1'b0;
        @(negedge clk);
        e = model(d2);
        check("b2b_first_bit", command, e[FW-1]);
        wait_done(t - 1, 1'b0);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
